// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic sensor conditioner.
// Holds the channel state encoding, parameter defaults, counter widths
// and a saturating increment helper for the vehicle counters.
package traffic_pkg;

    localparam int unsigned DEB_CYCLES_DEF   = 4;
    localparam int unsigned HOLD_CYCLES_DEF  = 8;
    localparam int unsigned STUCK_CYCLES_DEF = 1000;

    localparam int CNT_W = 16;
    localparam int VEH_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_QUAL_ON  = 3'd1,
        ST_PRESENT  = 3'd2,
        ST_QUAL_OFF = 3'd3,
        ST_FAULT    = 3'd4
    } chan_state_t;

    function automatic logic [VEH_W-1:0] sat_inc(input logic [VEH_W-1:0] v);
        return (v == {VEH_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sensor_chan.sv
// sensor_chan: one approach of the traffic sensor conditioner.
// Synchronizes the raw loop-detector level, debounces arrival and
// departure, detects a stuck detector and counts vehicle arrivals.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous reset, active low
//   raw      asynchronous loop-detector level
//   clr_cnt  synchronous clear of the vehicle counter
//   t        conditioned traffic-present (registered)
//   fault    stuck-detector flag (registered)
//   cnt      saturating vehicle arrival count
//
// state    | meaning
// IDLE     | no traffic, waiting for a high sample
// QUAL_ON  | counting consecutive high samples toward DEB_CYCLES
// PRESENT  | traffic declared, counting continuous-high samples for stuck
// QUAL_OFF | counting consecutive low samples toward HOLD_CYCLES
// FAULT    | detector stuck, traffic assumed until HOLD_CYCLES lows
module sensor_chan
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw,
    input  logic             clr_cnt,
    output logic             t,
    output logic             fault,
    output logic [VEH_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STUCK_C = CNT_W'(STUCK_CYCLES);

    logic             sync1;
    logic             raw_s;
    chan_state_t      state;
    logic [CNT_W-1:0] qual_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] stuck_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            raw_s <= 1'b0;
        end else begin
            sync1 <= raw;
            raw_s <= sync1;
        end
    end

    // Compares use "count + 1 >= limit" so the transition happens on the
    // very edge whose sample completes the run, giving the 2+N latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            qual_cnt  <= '0;
            hold_cnt  <= '0;
            stuck_cnt <= '0;
            t         <= 1'b0;
            fault     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    t     <= 1'b0;
                    fault <= 1'b0;
                    if (raw_s) begin
                        if (DEB_C <= CNT_W'(1)) begin
                            state     <= ST_PRESENT;
                            t         <= 1'b1;
                            stuck_cnt <= '0;
                            cnt       <= sat_inc(cnt);
                        end else begin
                            state    <= ST_QUAL_ON;
                            qual_cnt <= CNT_W'(1);
                        end
                    end
                end

                ST_QUAL_ON: begin
                    if (!raw_s) begin
                        state    <= ST_IDLE;
                        qual_cnt <= '0;
                    end else if (qual_cnt + CNT_W'(1) >= DEB_C) begin
                        state     <= ST_PRESENT;
                        t         <= 1'b1;
                        qual_cnt  <= '0;
                        stuck_cnt <= '0;
                        cnt       <= sat_inc(cnt);
                    end else begin
                        qual_cnt <= qual_cnt + CNT_W'(1);
                    end
                end

                ST_PRESENT: begin
                    if (!raw_s) begin
                        if (HOLD_C <= CNT_W'(1)) begin
                            state <= ST_IDLE;
                            t     <= 1'b0;
                        end else begin
                            state    <= ST_QUAL_OFF;
                            hold_cnt <= CNT_W'(1);
                        end
                    end else if (stuck_cnt + CNT_W'(1) >= STUCK_C) begin
                        state     <= ST_FAULT;
                        fault     <= 1'b1;
                        stuck_cnt <= '0;
                        hold_cnt  <= '0;
                    end else begin
                        stuck_cnt <= stuck_cnt + CNT_W'(1);
                    end
                end

                ST_QUAL_OFF: begin
                    if (raw_s) begin
                        state     <= ST_PRESENT;
                        stuck_cnt <= '0;
                        hold_cnt  <= '0;
                    end else if (hold_cnt + CNT_W'(1) >= HOLD_C) begin
                        state    <= ST_IDLE;
                        t        <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                ST_FAULT: begin
                    t <= 1'b1;
                    if (raw_s) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt + CNT_W'(1) >= HOLD_C) begin
                        state    <= ST_IDLE;
                        t        <= 1'b0;
                        fault    <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    t     <= 1'b0;
                    fault <= 1'b0;
                end
            endcase

            // Clear wins over a coincident arrival increment.
            if (clr_cnt) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond: two independent approach channels (A and B) that
// turn raw loop-detector levels into clean traffic-present signals,
// stuck-detector flags and saturating vehicle counts.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   raw_a, raw_b   asynchronous loop-detector levels
//   clr_cnt        synchronous clear of both vehicle counters
//   ta, tb         conditioned traffic-present per approach
//   cnt_a, cnt_b   vehicle arrival counts (saturate at 255)
//   fault_a/b      stuck-detector flag per approach
module traffic_sensor_cond
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw_a,
    input  logic             raw_b,
    input  logic             clr_cnt,
    output logic             ta,
    output logic             tb,
    output logic [VEH_W-1:0] cnt_a,
    output logic [VEH_W-1:0] cnt_b,
    output logic             fault_a,
    output logic             fault_b
);

    sensor_chan #(
        .DEB_CYCLES   (DEB_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) u_chan_a (
        .clk     (clk),
        .rst     (rst),
        .raw     (raw_a),
        .clr_cnt (clr_cnt),
        .t       (ta),
        .fault   (fault_a),
        .cnt     (cnt_a)
    );

    sensor_chan #(
        .DEB_CYCLES   (DEB_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) u_chan_b (
        .clk     (clk),
        .rst     (rst),
        .raw     (raw_b),
        .clr_cnt (clr_cnt),
        .t       (tb),
        .fault   (fault_b),
        .cnt     (cnt_b)
    );

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Bench for traffic_sensor_cond with default parameters: constant-expectation
// vector table, hand-written corner sequences, then random stimulus, with
// every clock also compared against a run-length reference model.
module tb_traffic_sensor_cond;

    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int STUCK = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       raw_a = 1'b0;
    logic       raw_b = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       ta, tb, fault_a, fault_b;
    logic [7:0] cnt_a, cnt_b;

    int total = 0;
    int bad   = 0;

    traffic_sensor_cond dut (
        .clk     (clk),
        .rst     (rst),
        .raw_a   (raw_a),
        .raw_b   (raw_b),
        .clr_cnt (clr_cnt),
        .ta      (ta),
        .tb      (tb),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b),
        .fault_a (fault_a),
        .fault_b (fault_b)
    );

    always #5 clk = ~clk;

    // Reference model: per channel, the synchronizer delay plus run lengths
    // of identical samples decide presence, stuck and clear.
    int m_s1[2], m_s2[2], m_hi[2], m_lo[2], m_stk[2], m_cnt[2];
    bit m_pres[2], m_flt[2], m_prev[2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_hi[c] = 0; m_lo[c] = 0;
            m_stk[c] = 0; m_cnt[c] = 0;
            m_pres[c] = 0; m_flt[c] = 0; m_prev[c] = 0;
        end
    endtask

    task automatic model_edge(input bit ra, input bit rb, input bit clr);
        for (int c = 0; c < 2; c++) begin
            bit s;
            s = (m_s2[c] != 0);
            m_s2[c] = m_s1[c];
            m_s1[c] = (c == 0) ? int'(ra) : int'(rb);
            if (s) begin m_hi[c]++; m_lo[c] = 0; end
            else   begin m_lo[c]++; m_hi[c] = 0; end
            if (!m_pres[c]) begin
                if (s && m_hi[c] >= DEB) begin
                    m_pres[c] = 1;
                    m_stk[c] = 0;
                    if (m_cnt[c] < 255) m_cnt[c]++;
                end
            end else if (m_flt[c]) begin
                if (!s && m_lo[c] >= HOLD) begin
                    m_pres[c] = 0;
                    m_flt[c] = 0;
                end
            end else if (s) begin
                // a high after a low while present restarts the stuck run
                if (m_prev[c]) m_stk[c]++;
                else m_stk[c] = 0;
                if (m_stk[c] >= STUCK) m_flt[c] = 1;
            end else if (m_lo[c] >= HOLD) begin
                m_pres[c] = 0;
            end
            m_prev[c] = s;
            if (clr) m_cnt[c] = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("m_ta", int'(ta), int'(m_pres[0]));
        check("m_tb", int'(tb), int'(m_pres[1]));
        check("m_fault_a", int'(fault_a), int'(m_flt[0]));
        check("m_fault_b", int'(fault_b), int'(m_flt[1]));
        check("m_cnt_a", int'(cnt_a), m_cnt[0]);
        check("m_cnt_b", int'(cnt_b), m_cnt[1]);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge(raw_a, raw_b, clr_cnt);
            #1;
            compare_model();
        end
    endtask

    typedef struct {
        bit ra, rb, clr;
        int n;
        bit e_ta, e_tb;
        int e_ca, e_cb;
    } vec_t;

    vec_t vt[$];

    initial begin
        // raw_a 20 cycles high, then release
        vt.push_back('{1, 0, 0, 5,  0, 0, 0, 0});
        vt.push_back('{1, 0, 0, 1,  1, 0, 1, 0});
        vt.push_back('{1, 0, 0, 14, 1, 0, 1, 0});
        vt.push_back('{0, 0, 0, 9,  1, 0, 1, 0});
        vt.push_back('{0, 0, 0, 1,  0, 0, 1, 0});
        // 3-cycle glitch is rejected
        vt.push_back('{1, 0, 0, 3,  0, 0, 1, 0});
        vt.push_back('{0, 0, 0, 6,  0, 0, 1, 0});
        // second vehicle, short 4-cycle gap keeps it present
        vt.push_back('{1, 0, 0, 20, 1, 0, 2, 0});
        vt.push_back('{0, 0, 0, 4,  1, 0, 2, 0});
        vt.push_back('{1, 0, 0, 6,  1, 0, 2, 0});
        vt.push_back('{0, 0, 0, 12, 0, 0, 2, 0});
        // simultaneous arrival on A and B
        vt.push_back('{1, 1, 0, 5,  0, 0, 2, 0});
        vt.push_back('{1, 1, 0, 1,  1, 1, 3, 1});
        vt.push_back('{0, 0, 1, 1,  1, 1, 0, 0});
        vt.push_back('{0, 0, 0, 12, 0, 0, 0, 0});

        model_reset();
        #12;
        check("reset_ta", int'(ta), 0);
        check("reset_tb", int'(tb), 0);
        check("reset_cnt_a", int'(cnt_a), 0);
        check("reset_cnt_b", int'(cnt_b), 0);
        check("reset_fault_a", int'(fault_a), 0);
        check("reset_fault_b", int'(fault_b), 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vt[k]) begin
            raw_a = vt[k].ra; raw_b = vt[k].rb; clr_cnt = vt[k].clr;
            tick(vt[k].n);
            check($sformatf("vec%0d_ta", k), int'(ta), int'(vt[k].e_ta));
            check($sformatf("vec%0d_tb", k), int'(tb), int'(vt[k].e_tb));
            check($sformatf("vec%0d_cnt_a", k), int'(cnt_a), vt[k].e_ca);
            check($sformatf("vec%0d_cnt_b", k), int'(cnt_b), vt[k].e_cb);
        end
        clr_cnt = 0;

        // stuck detector on B
        raw_b = 1;
        tick(1005);
        check("stuck_pre_fault_b", int'(fault_b), 0);
        tick(1);
        check("stuck_fault_b", int'(fault_b), 1);
        check("stuck_tb", int'(tb), 1);
        tick(194);
        raw_b = 0;
        tick(9);
        check("stuck_hold_fault_b", int'(fault_b), 1);
        check("stuck_hold_tb", int'(tb), 1);
        tick(1);
        check("stuck_clear_fault_b", int'(fault_b), 0);
        check("stuck_clear_tb", int'(tb), 0);
        tick(4);

        // counter saturation and clear coincident with an arrival
        for (int v = 0; v < 300; v++) begin
            raw_a = 1; tick(6);
            raw_a = 0; tick(10);
        end
        check("sat_cnt_a", int'(cnt_a), 255);
        raw_a = 1;
        tick(5);
        clr_cnt = 1;
        tick(1);
        clr_cnt = 0;
        check("clr_on_inc_cnt_a", int'(cnt_a), 0);
        check("clr_on_inc_ta", int'(ta), 1);
        raw_a = 0;
        tick(12);

        // async reset mid-qualification (A) and while present (B)
        raw_b = 1;
        tick(8);
        raw_a = 1;
        tick(5);
        check("pre_rst_tb", int'(tb), 1);
        #2;
        rst = 0;
        #1;
        model_reset();
        check("async_rst_ta", int'(ta), 0);
        check("async_rst_tb", int'(tb), 0);
        check("async_rst_cnt_b", int'(cnt_b), 0);
        check("async_rst_fault_b", int'(fault_b), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        tick(5);
        check("rst_release_ta_low", int'(ta), 0);
        tick(1);
        check("rst_release_ta_rise", int'(ta), 1);
        check("rst_release_tb_rise", int'(tb), 1);
        raw_a = 0; raw_b = 0;
        tick(12);

        // random bursty stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) raw_a = ~raw_a;
            if ($urandom_range(0, 5) == 0) raw_b = ~raw_b;
            clr_cnt = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        clr_cnt = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_cond.md
TRAFFIC_SENSOR_COND -- requirements
Module: traffic_sensor_cond

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, meaning consecutive synchronized-high samples needed to declare a vehicle present (legal 1..65535).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, meaning consecutive synchronized-low samples needed to declare the approach clear (legal 1..65535).
REQ-003 SHALL have parameter STUCK_CYCLES, default 1000, meaning continuous-present samples after which the detector is declared stuck (legal DEB_CYCLES+1..65535).
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port raw_a  input  1  asynchronous loop-detector level, approach A.
REQ-007 SHALL have port raw_b  input  1  asynchronous loop-detector level, approach B.
REQ-008 SHALL have port clr_cnt  input  1  synchronous clear of both vehicle counters.
REQ-009 SHALL have port ta  output  1  conditioned traffic-present, approach A (feeds light controller).
REQ-010 SHALL have port tb  output  1  conditioned traffic-present, approach B.
REQ-011 SHALL have port cnt_a  output  8  vehicle arrivals counted on A.
REQ-012 SHALL have port cnt_b  output  8  vehicle arrivals counted on B.
REQ-013 SHALL have port fault_a / fault_b  output  1 each  stuck-detector flag per approach.

Function
REQ-014 SHALL pass each raw input through a 2-flop synchronizer; raw_s denotes the second flop output.
REQ-015 SHALL run one independent channel FSM per approach, states IDLE, QUAL_ON, PRESENT, QUAL_OFF, FAULT; channels share no state.
REQ-016 IDLE: t=0; raw_s=1 -> QUAL_ON with qualify count 1.
REQ-017 QUAL_ON: t=0; raw_s=0 -> IDLE, count discarded; count reaching DEB_CYCLES on a raw_s=1 edge -> PRESENT, vehicle counter +1.
REQ-018 DEB_CYCLES=1 SHALL move IDLE -> PRESENT directly on first raw_s=1 edge, counting the vehicle.
REQ-019 PRESENT: t=1; raw_s=0 -> QUAL_OFF with hold count 1; raw_s=1 increments stuck count; stuck count reaching STUCK_CYCLES -> FAULT.
REQ-020 QUAL_OFF: t=1; raw_s=1 -> PRESENT, stuck count restarted, no vehicle increment; hold count reaching HOLD_CYCLES -> IDLE.
REQ-021 FAULT: t=1 (fail-safe: assume traffic), fault=1; HOLD_CYCLES consecutive raw_s=0 edges -> IDLE, fault=0; any raw_s=1 restarts that count.
REQ-022 Latency: with raw stable high from before edge 1, t SHALL rise after edge 2+DEB_CYCLES; with raw stable low from before edge 1, t SHALL fall after edge 2+HOLD_CYCLES.
REQ-023 ta, tb, fault_a, fault_b SHALL be registered outputs (no combinational path from raw inputs).
REQ-024 Vehicle counters SHALL saturate at 255, never wrap.
REQ-025 clr_cnt SHALL set both counters to 0 on the next edge; clr_cnt coincident with an increment SHALL yield 0.
REQ-026 Simultaneous events on A and B SHALL be handled independently in the same cycle.

Reset
REQ-027 rst=0 SHALL asynchronously force: synchronizer flops 0, both FSMs IDLE, all internal counts 0, ta=tb=0, cnt_a=cnt_b=0, fault_a=fault_b=0.
REQ-028 Reset asserted mid-qualification or mid-hold SHALL discard the partial count; after release qualification restarts from raw_s.
REQ-029 Reset release SHALL take effect on the first clk edge after rst rises; no other reset action.

Structure
REQ-030 Channel state encoding (3-bit, 5 states) and parameter defaults SHALL live in shared package traffic_pkg.
REQ-031 Per-approach logic (synchronizer, FSM, qualify/hold/stuck counters, vehicle counter) SHALL be sub-module sensor_chan, instantiated twice; top level is wiring only.
REQ-032 Internal counters SHALL be 16 bits.

Verification
REQ-033 Defaults; raw_a high for 20 cycles from reset release -> ta rises after edge 6, cnt_a=1, tb=0, cnt_b=0.
REQ-034 raw_a glitch high 3 cycles -> ta stays 0, cnt_a stays 0; then 4-cycle gap low in PRESENT (<8) -> ta stays 1, cnt_a unchanged.
REQ-035 raw_b held high 1200 cycles -> tb=1, fault_b rises when stuck count hits 1000; raw_b low -> fault_b and tb fall after 2+8 edges.
REQ-036 300 clean vehicles on A -> cnt_a=255; assert clr_cnt on the edge of the 301st increment -> cnt_a=0.
REQ-037 rst pulsed low while A in QUAL_ON (count 3) and B in PRESENT -> all outputs 0 immediately without clock; raw_a still high after release -> ta rises 6 edges later.
REQ-038 raw_a and raw_b rise on the same edge -> ta and tb rise on the same edge, cnt_a=cnt_b=1.
